// File: rtl/rv32_pipeline_pkg.sv
// Shared pipeline types for the RV32 front end: instruction word and the
// {pc, instruction} record carried from fetch to decode.
package rv32_pipeline_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instruction;
  } fetch_entry_t;

  localparam word_t PC_STEP = 32'd4;

  // Fetch addresses are always word aligned; the low two bits are dropped.
  function automatic word_t align_pc(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv32_fetch_queue_if.sv
// Signal bundle between the fetch queue, the instruction memory and decode.
// Handshakes: a transfer happens on a rising edge where valid && ready.
// valid never depends on ready; the request address is held while stalled.
interface rv32_fetch_queue_if;
  import rv32_pipeline_pkg::*;

  logic  imem_req_valid;
  logic  imem_req_ready;
  word_t imem_req_addr;
  logic  imem_rsp_valid;
  word_t imem_rsp_data;
  logic  if_valid;
  logic  if_ready;
  word_t if_instruction;
  word_t if_pc;
  logic  redirect_valid;
  word_t redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instruction, if_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instruction, if_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/rv32_fetch_fifo.sv
// Circular FIFO of fetch entries with synchronous flush; pointers wrap at
// DEPTH (power of two). A push is accepted when full if a pop happens too.
module rv32_fetch_fifo
  import rv32_pipeline_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: nothing is read until count says it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rv32_fetch_queue.sv
// RV32 instruction fetch queue: issues sequential fetches, tags responses
// with their PC, buffers them for decode and flushes on redirect.
// Optional same-cycle bypass is enabled with macro RV32_FETCH_BYPASS_EN.
module rv32_fetch_queue
  import rv32_pipeline_pkg::*;
#(
  parameter word_t PC_RESET_VALUE = 32'h0000_0000,
  parameter int    DEPTH          = 4
) (
  input  logic  clk,
  input  logic  rst,
  output logic  imem_req_valid,
  input  logic  imem_req_ready,
  output word_t imem_req_addr,
  input  logic  imem_rsp_valid,
  input  word_t imem_rsp_data,
  output logic  if_valid,
  input  logic  if_ready,
  output word_t if_instruction,
  output word_t if_pc,
  input  logic  redirect_valid,
  input  word_t redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] occupancy;
  logic [CW:0]   in_use;
  word_t         fetch_pc;
  word_t         rsp_pc;

  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  fetch_entry_t  fifo_head;
  fetch_entry_t  rsp_entry;
  fetch_entry_t  out_entry;

  logic          req_fire;
  logic          rsp_keep;
  logic          bypass_hit;
  logic          out_fire;

  // Credit check counts in-flight requests too, so a response always has room.
  assign in_use         = {1'b0, occupancy} + {1'b0, outstanding};
  assign imem_req_valid = !rst && !redirect_valid && (in_use < (CW+1)'(DEPTH));
  assign imem_req_addr  = rst ? '0 : fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_keep  = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
  assign rsp_entry = '{pc: rsp_pc, instruction: imem_rsp_data};

`ifdef RV32_FETCH_BYPASS_EN
  assign bypass_hit = rsp_keep && fifo_empty;
`else
  assign bypass_hit = 1'b0;
`endif

  assign out_entry      = fifo_empty ? rsp_entry : fifo_head;
  assign if_valid       = !rst && !redirect_valid && (!fifo_empty || bypass_hit);
  assign if_pc          = rst ? '0 : out_entry.pc;
  assign if_instruction = rst ? '0 : out_entry.instruction;
  assign out_fire       = if_valid && if_ready;

  assign fifo_pop  = out_fire && !fifo_empty;
  assign fifo_push = rsp_keep && !(bypass_hit && if_ready) && (!fifo_full || fifo_pop);

  rv32_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (fifo_push),
    .wdata (rsp_entry),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy)
  );

  // Every arriving response retires one outstanding request, kept or dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      drop_cnt    <= '0;
      fetch_pc    <= PC_RESET_VALUE;
      rsp_pc      <= PC_RESET_VALUE;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc <= align_pc(redirect_pc);
        rsp_pc   <= align_pc(redirect_pc);
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
        if (rsp_keep) rsp_pc   <= rsp_pc + PC_STEP;
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

endmodule
